// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - two-requester round-robin UART transmitter with optional parity
module uart_tx_arbiter #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic [1:0] grant,
    output logic       busy,
    output logic       done,
    output logic       txd
);

    localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic          ODD_BIT   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          r_state;
    logic [1:0]      r_req;
    logic [1:0]      r_grant;
    logic [CW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_par;
    logic            r_last;
    logic            r_busy;
    logic            r_done;
    logic            r_txd;

    logic            w_pick1;
    logic [7:0]      w_sel;
    logic            w_bit_end;

    // Requester 1 wins when it is alone, or when both ask and 0 was served last.
    assign w_pick1   = r_req[1] & (~r_req[0] | ~r_last);
    assign w_sel     = w_pick1 ? data1 : data0;
    assign w_bit_end = (r_baud == BAUD_LAST);

    assign grant = r_grant;
    assign busy  = r_busy;
    assign done  = r_done;
    assign txd   = r_txd;

    // Arbitration, baud timing and frame sequencing; all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_req   <= 2'b00;
            r_grant <= 2'b00;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_par   <= 1'b0;
            r_last  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_txd   <= 1'b1;
        end else begin
            r_req   <= req;
            r_grant <= 2'b00;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_req != 2'b00) begin
                        r_grant <= w_pick1 ? 2'b10 : 2'b01;
                        r_last  <= w_pick1;
                        r_shift <= w_sel;
                        r_par   <= (^w_sel) ^ ODD_BIT;
                        r_busy  <= 1'b1;
                        r_txd   <= 1'b0;
                        r_baud  <= '0;
                        r_bit   <= 3'd0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_txd   <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_bit   <= 3'd0;
                        r_state <= DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                r_txd   <= r_par;
                                r_state <= PARITY;
                            end else begin
                                r_txd   <= 1'b1;
                                r_state <= STOP;
                            end
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_txd   <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                PARITY: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_txd   <= 1'b1;
                        r_state <= STOP;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;

    logic [1:0] grant, pe_grant, po_grant;
    logic       busy, pe_busy, po_busy;
    logic       done, pe_done, po_done;
    logic       txd, pe_txd, po_txd;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
        .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
        .grant(grant), .busy(busy), .done(done), .txd(txd)
    );

    uart_tx_arbiter #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_par_even (
        .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
        .grant(pe_grant), .busy(pe_busy), .done(pe_done), .txd(pe_txd)
    );

    uart_tx_arbiter #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_par_odd (
        .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
        .grant(po_grant), .busy(po_busy), .done(po_done), .txd(po_txd)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b0;
        req = 2'b00;
        repeat (2) tick;
        rst = 1'b1;
        tick;
    endtask

    task automatic wait_grant(output logic [1:0] g, output int waited);
        g = 2'b00;
        waited = 0;
        while (g == 2'b00 && waited < 20) begin
            tick;
            waited++;
            if (grant !== 2'b00) g = grant;
        end
    endtask

    // Called in the grant cycle; returns in the cycle where done is expected.
    task automatic capture(input int chg_cycle, input logic [7:0] chg_val,
                           output logic [9:0] bits, output int done_at,
                           output int busy_bad, output int grant_extra);
        bits = '0;
        done_at = -1;
        busy_bad = 0;
        grant_extra = 0;
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) tick;
            if (c % 4 == 2) bits[c/4] = txd;
            if (c < 40 && busy !== 1'b1) busy_bad++;
            if (c > 0 && grant !== 2'b00) grant_extra++;
            if (done === 1'b1 && done_at < 0) done_at = c;
            if (c == chg_cycle) data0 = chg_val;
        end
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        #1;
        n_total++; if (txd !== 1'b1) $display("FAIL reset_txd: got %b expected 1", txd); else n_pass++;
        n_total++; if (grant !== 2'b00) $display("FAIL reset_grant: got %b expected 00", grant); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        repeat (2) tick;
        rst = 1'b1;
        repeat (3) tick;
        n_total++; if (txd !== 1'b1 || busy !== 1'b0) $display("FAIL idle_after_reset: txd=%b busy=%b expected 1 0", txd, busy); else n_pass++;
    endtask

    task automatic test_single_frame;
        logic [1:0] g;
        logic [9:0] bits;
        int waited, done_at, busy_bad, gx;
        apply_reset;
        data0 = 8'hA5;
        req = 2'b01;
        wait_grant(g, waited);
        req = 2'b00;
        n_total++; if (g !== 2'b01) $display("FAIL single_grant: got %b expected 01", g); else n_pass++;
        n_total++; if (txd !== 1'b0) $display("FAIL single_txd_at_grant: got %b expected 0", txd); else n_pass++;
        capture(-1, 8'h00, bits, done_at, busy_bad, gx);
        n_total++; if (bits !== 10'b1101001010) $display("FAIL single_bits: got %b expected 1101001010", bits); else n_pass++;
        n_total++; if (done_at != 40) $display("FAIL single_done_time: got %0d expected 40", done_at); else n_pass++;
        n_total++; if (busy_bad != 0) $display("FAIL single_busy: got %0d low cycles expected 0", busy_bad); else n_pass++;
        n_total++; if (gx != 0) $display("FAIL single_grant_pulse: got %0d extra grant cycles expected 0", gx); else n_pass++;
        n_total++; if (busy !== 1'b0 || txd !== 1'b1) $display("FAIL single_done_cycle: busy=%b txd=%b expected 0 1", busy, txd); else n_pass++;
        tick;
        n_total++; if (done !== 1'b0) $display("FAIL single_done_pulse: got %b expected 0", done); else n_pass++;
    endtask

    task automatic test_round_robin;
        logic [1:0] g;
        logic [1:0] exp_g;
        logic [7:0] exp_d;
        logic [9:0] bits;
        int waited, done_at, busy_bad, gx;
        apply_reset;
        data0 = 8'h11;
        data1 = 8'h22;
        req = 2'b11;
        for (int f = 0; f < 4; f++) begin
            exp_g = (f % 2 == 0) ? 2'b01 : 2'b10;
            exp_d = (f % 2 == 0) ? 8'h11 : 8'h22;
            wait_grant(g, waited);
            n_total++; if (g !== exp_g) $display("FAIL rr_grant%0d: got %b expected %b", f, g, exp_g); else n_pass++;
            if (f > 0) begin
                n_total++; if (waited != 1) $display("FAIL rr_gap%0d: got %0d cycles expected 1", f, waited); else n_pass++;
            end
            capture(-1, 8'h00, bits, done_at, busy_bad, gx);
            n_total++; if (bits !== {1'b1, exp_d, 1'b0}) $display("FAIL rr_bits%0d: got %b expected %b", f, bits, {1'b1, exp_d, 1'b0}); else n_pass++;
            n_total++; if (done_at != 40) $display("FAIL rr_done%0d: got %0d expected 40", f, done_at); else n_pass++;
            n_total++; if (txd !== 1'b1 || busy !== 1'b0 || grant !== 2'b00) $display("FAIL rr_idle%0d: txd=%b busy=%b grant=%b expected 1 0 00", f, txd, busy, grant); else n_pass++;
        end
        req = 2'b00;
    endtask

    task automatic test_parity;
        logic [10:0] be, bo;
        int de, dob, n;
        apply_reset;
        data0 = 8'h07;
        req = 2'b01;
        n = 0;
        while (pe_grant === 2'b00 && n < 20) begin
            tick;
            n++;
        end
        req = 2'b00;
        n_total++; if (pe_grant !== 2'b01 || po_grant !== 2'b01) $display("FAIL parity_grant: even=%b odd=%b expected 01 01", pe_grant, po_grant); else n_pass++;
        be = '0; bo = '0; de = -1; dob = -1;
        for (int c = 0; c <= 44; c++) begin
            if (c > 0) tick;
            if (c % 4 == 2) begin
                be[c/4] = pe_txd;
                bo[c/4] = po_txd;
            end
            if (pe_done === 1'b1 && de < 0) de = c;
            if (po_done === 1'b1 && dob < 0) dob = c;
        end
        n_total++; if (be !== 11'b11000001110) $display("FAIL parity_even_bits: got %b expected 11000001110", be); else n_pass++;
        n_total++; if (bo !== 11'b10000001110) $display("FAIL parity_odd_bits: got %b expected 10000001110", bo); else n_pass++;
        n_total++; if (de != 44) $display("FAIL parity_even_len: got %0d expected 44", de); else n_pass++;
        n_total++; if (dob != 44) $display("FAIL parity_odd_len: got %0d expected 44", dob); else n_pass++;
    endtask

    task automatic test_reset_midframe;
        logic [1:0] g;
        logic [9:0] bits;
        int waited, done_at, busy_bad, gx;
        apply_reset;
        data0 = 8'h00;
        req = 2'b01;
        wait_grant(g, waited);
        req = 2'b00;
        repeat (13) tick;
        n_total++; if (txd !== 1'b0 || busy !== 1'b1) $display("FAIL midframe_before: txd=%b busy=%b expected 0 1", txd, busy); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_total++; if (txd !== 1'b1 || busy !== 1'b0) $display("FAIL midframe_async: txd=%b busy=%b expected 1 0", txd, busy); else n_pass++;
        tick;
        data1 = 8'h5A;
        req = 2'b10;
        rst = 1'b1;
        wait_grant(g, waited);
        req = 2'b00;
        n_total++; if (g !== 2'b10) $display("FAIL midframe_regrant: got %b expected 10", g); else n_pass++;
        capture(-1, 8'h00, bits, done_at, busy_bad, gx);
        n_total++; if (bits !== {1'b1, 8'h5A, 1'b0}) $display("FAIL midframe_bits: got %b expected %b", bits, {1'b1, 8'h5A, 1'b0}); else n_pass++;
        n_total++; if (done_at != 40 || busy_bad != 0) $display("FAIL midframe_frame: done_at=%0d busy_bad=%0d expected 40 0", done_at, busy_bad); else n_pass++;
    endtask

    task automatic test_ignore_req;
        logic [1:0] g;
        int waited, bad_grant, bad_idle, done_at;
        apply_reset;
        data0 = 8'hA5;
        data1 = 8'h99;
        req = 2'b01;
        wait_grant(g, waited);
        req = 2'b00;
        bad_grant = 0;
        bad_idle = 0;
        done_at = -1;
        for (int c = 1; c <= 40; c++) begin
            tick;
            if (c == 8) req = 2'b10;
            if (c == 30) req = 2'b00;
            if (grant !== 2'b00) bad_grant++;
            if (done === 1'b1 && done_at < 0) done_at = c;
        end
        for (int c = 0; c < 20; c++) begin
            tick;
            if (grant !== 2'b00) bad_grant++;
            if (txd !== 1'b1 || busy !== 1'b0) bad_idle++;
        end
        n_total++; if (done_at != 40) $display("FAIL ignore_done: got %0d expected 40", done_at); else n_pass++;
        n_total++; if (bad_grant != 0) $display("FAIL ignore_grant: got %0d grant cycles expected 0", bad_grant); else n_pass++;
        n_total++; if (bad_idle != 0) $display("FAIL ignore_idle: got %0d non-idle cycles expected 0", bad_idle); else n_pass++;
    endtask

    task automatic test_data_change;
        logic [1:0] g;
        logic [9:0] bits;
        int waited, done_at, busy_bad, gx;
        apply_reset;
        data0 = 8'h3C;
        req = 2'b01;
        wait_grant(g, waited);
        req = 2'b00;
        capture(10, 8'hFF, bits, done_at, busy_bad, gx);
        n_total++; if (bits !== {1'b1, 8'h3C, 1'b0}) $display("FAIL datachg_bits: got %b expected %b", bits, {1'b1, 8'h3C, 1'b0}); else n_pass++;
        n_total++; if (done_at != 40) $display("FAIL datachg_done: got %0d expected 40", done_at); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_round_robin;
        test_parity;
        test_reset_midframe;
        test_ignore_req;
        test_data_change;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
